cfg_frame_ctrl: RTL

Framed configuration controller between the UART byte receiver and the four channel output modules. It parses checksummed command frames into a shadow register bank. On a commit command it transfers the whole bank into the active timing registers (`delay_set_a..d`, `duty_cycle`, `sub_clk_feq`, `sub_clk_scl`) atomically at the next output-period boundary, so channels never run on a mix of old and new settings.

---
 rtl/cfg_frame_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cfg_frame_ctrl.sv
// cfg_frame_ctrl: framed configuration controller.
// Parses 0xA5-led command frames from the UART byte stream into a shadow
// register bank and moves the whole bank to the active timing registers at
// the next period_tick after a commit command, so channels never see a mix
// of old and new settings.
//
// Build option: define CFG_CHECKSUM_EN for 5-byte frames with an XOR
// checksum byte (A5 ADDR DHI DLO CSUM). Without it, frames are 4 bytes
// (A5 ADDR DHI DLO) and are accepted on DLO with no checksum check.
//
// Byte input handshake: rx_valid is a one-cycle strobe qualifying rx_data.
// There is no ready/backpressure; every strobed byte is consumed on the edge
// that samples it, including strobes on consecutive cycles.
//
// dbg_state_o exposes the parser state (IDLE=0, ADDR=1, DHI=2, DLO=3, CSUM=4).
module cfg_frame_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [15:0] DUTY_RST    = 16'd10,
  parameter logic [15:0] FEQ_RST     = 16'd50000,
  parameter logic [15:0] SCL_RST     = 16'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        period_tick,
  output logic [15:0] delay_set_a,
  output logic [15:0] delay_set_b,
  output logic [15:0] delay_set_c,
  output logic [15:0] delay_set_d,
  output logic [15:0] duty_cycle,
  output logic [15:0] sub_clk_feq,
  output logic [15:0] sub_clk_scl,
  output logic        cfg_update,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        commit_pend,
  output logic [2:0]  dbg_state_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] SOF_BYTE   = 8'hA5;
  localparam logic [7:0] ADDR_LAST  = 8'd6;
  localparam logic [7:0] ADDR_COMMIT = 8'h0F;

  // Bank slot order: delay a..d, duty, feq, scl (slot index == frame address).
  localparam logic [15:0] RST_VAL [7] = '{16'd0, 16'd0, 16'd0, 16'd0,
                                          DUTY_RST, FEQ_RST, SCL_RST};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3
`ifdef CFG_CHECKSUM_EN
    , ST_CSUM = 3'd4
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]      addr_q;
  logic [7:0]      dhi_q;
`ifdef CFG_CHECKSUM_EN
  logic [7:0]      dlo_q;
`endif
  logic [15:0]     shd_q [7];
  logic [15:0]     act_q [7];
  logic            pend_q, pend_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic            upd_q;

  logic            frame_done;
  logic            timeout;
  logic            csum_ok;
  logic [15:0]     fr_word;
  logic            wr_en;
  logic            commit_acc;
  logic            commit_fire;

  // Frame decode: checksum check and data word of the frame completing now.
`ifdef CFG_CHECKSUM_EN
  assign fr_word = {dhi_q, dlo_q};
  assign csum_ok = (rx_data == (addr_q ^ dhi_q ^ dlo_q));
`else
  assign fr_word = {dhi_q, rx_data};
  assign csum_ok = 1'b1;
`endif

  assign wr_en       = frame_done & csum_ok & (addr_q <= ADDR_LAST);
  assign commit_acc  = frame_done & csum_ok & (addr_q == ADDR_COMMIT);
  // A commit accepted on this edge is not yet pending, so it cannot fire here.
  assign commit_fire = pend_q & period_tick;

  // Parser next-state, idle timeout and status pulse generation.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    timeout    = (state_q != ST_IDLE) && !rx_valid && (to_cnt_q == TO_LAST);
    case (state_q)
      ST_IDLE: if (rx_valid && rx_data == SOF_BYTE) state_d = ST_ADDR;
      ST_ADDR: if (rx_valid) state_d = ST_DHI;
      ST_DHI:  if (rx_valid) state_d = ST_DLO;
`ifdef CFG_CHECKSUM_EN
      ST_DLO:  if (rx_valid) state_d = ST_CSUM;
      ST_CSUM: if (rx_valid) begin
        state_d    = ST_IDLE;
        frame_done = 1'b1;
      end
`else
      ST_DLO:  if (rx_valid) begin
        state_d    = ST_IDLE;
        frame_done = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_IDLE;

    // Counts cycles without a byte while mid-frame; parked at 0 in IDLE.
    if (rx_valid || state_q == ST_IDLE || timeout) to_cnt_d = '0;
    else                                           to_cnt_d = to_cnt_q + TW'(1);

    ok_d  = wr_en | commit_acc;
    err_d = (frame_done & ~(wr_en | commit_acc)) | timeout;

    // A new commit on the firing edge stays pending for the next tick.
    pend_d = pend_q;
    if (commit_fire) pend_d = 1'b0;
    if (commit_acc)  pend_d = 1'b1;
  end

  // FSM state, timeout counter and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      to_cnt_q <= '0;
      pend_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      pend_q   <= pend_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      upd_q    <= commit_fire;
    end
  end

  // Field capture plus shadow and active banks; commit copies pre-write shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      dhi_q  <= '0;
`ifdef CFG_CHECKSUM_EN
      dlo_q  <= '0;
`endif
      for (int i = 0; i < 7; i++) begin
        shd_q[i] <= RST_VAL[i];
        act_q[i] <= RST_VAL[i];
      end
    end else begin
      if (rx_valid && state_q == ST_ADDR) addr_q <= rx_data;
      if (rx_valid && state_q == ST_DHI)  dhi_q  <= rx_data;
`ifdef CFG_CHECKSUM_EN
      if (rx_valid && state_q == ST_DLO)  dlo_q  <= rx_data;
`endif
      for (int i = 0; i < 7; i++) begin
        if (wr_en && addr_q == 8'(i)) shd_q[i] <= fr_word;
        if (commit_fire)              act_q[i] <= shd_q[i];
      end
    end
  end

  assign delay_set_a = act_q[0];
  assign delay_set_b = act_q[1];
  assign delay_set_c = act_q[2];
  assign delay_set_d = act_q[3];
  assign duty_cycle  = act_q[4];
  assign sub_clk_feq = act_q[5];
  assign sub_clk_scl = act_q[6];
  assign cfg_update  = upd_q;
  assign frame_ok    = ok_q;
  assign frame_err   = err_q;
  assign commit_pend = pend_q;
  assign dbg_state_o = state_q;

endmodule
